adc_responder: RTL and testbench
================================

Name: adc_responder

Overview:
- Synthesizable emulation of the parallel 8-bit ADC that the PMIC controller drives; it is the responder end of the convStart / busy / rd_cs / data handshake.
- Used in loopback test builds and as the DUT-side partner in controller-level benches.
- Accepts a conversion request, holds busy for a fixed conversion time, and latches a sample. When chip-select is asserted, it drives the result onto the data bus.

Parameters:
- DATA_W, 8, sample/result width.
- CONV_CYCLES, 12, busy-high duration in clk cycles (legal range 2..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; when low, FSM held in IDLE and outputs at reset values
- conv_start  in  1  conversion request, rising-edge sensitive, active high
- rd_cs  in  1  combined read/chip-select, active high (matches controller uo_out[1] polarity)
- sample_in  in  DATA_W  value "sampled" by the emulated ADC
- busy  out  1  high while converting
- data_out  out  DATA_W  conversion result bus
- data_oe  out  1  data bus drive enable
- overrun  out  1  sticky: conv_start edge arrived while busy

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - busy=0, data_out=0, data_oe=0, overrun=0.
  - result register=0, FSM=IDLE, edge-detect flop=0, counter=0.
- Edge detect: a rising edge is a cycle where conv_start=1 and the previous sampled conv_start=0.
- FSM states: IDLE, CONVERT, READY.
- IDLE or READY + rising edge:
  - sample_in latched into shadow register.
  - counter=CONV_CYCLES-1, go to CONVERT.
  - busy=1 from the next cycle.
- CONVERT:
  - counter decrements each cycle; busy stays high for exactly CONV_CYCLES cycles.
  - At counter==0: result<=shadow, busy<=0, go to READY.
  - Rising edge while in CONVERT: ignored (no re-latch, counter untouched); overrun<=1.
- READY: holds result indefinitely; a new edge restarts conversion per the IDLE/READY rule.
- Read path (registered, 1-cycle latency):
  - data_oe<=rd_cs & ~busy.
  - data_out<=result when rd_cs & ~busy, else 0.
  - rd_cs asserted while busy: data_oe stays 0 until the cycle after busy falls, provided rd_cs is still high.
- Read before any conversion (IDLE): drives result=0.
- overrun clears only on reset or ena low.
- Simultaneous final conversion cycle and a new edge: the conversion completes; the edge is treated as arriving in CONVERT (overrun set, not restarted).
- ena low mid-conversion: immediate return to IDLE, busy=0, data_oe=0. The result register retains its last completed value.
- rst_n low mid-operation: all state to reset values asynchronously.

Optional Feature:
- Macro: ADC_RESPONDER_NOISE_EN.
- When defined:
  - An 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances every cycle.
  - At completion, result<=shadow XOR {6'b0, lfsr[1:0]}, giving ±LSB-level jitter for controller-filter testing.
- When undefined: no LFSR logic; result==shadow exactly.

Decomposition:
- Package adc_responder_pkg:
  - state enum (IDLE, CONVERT, READY).
  - DATA_W default constant.
  - LFSR seed and tap constants.
- One natural sub-module, adc_conv_timer:
  - loadable down-counter with a done pulse.
  - used by the FSM for CONVERT timing.

Test Plan:
- Reset check: hold rst_n=0 with conv_start toggling -> busy=0, data_oe=0, data_out=0, overrun=0.
- Basic conversion: sample_in=8'h5C, pulse conv_start 1 cycle -> busy high 12 cycles starting the cycle after the edge. Then rd_cs=1 -> data_oe=1, data_out=8'h5C one cycle later.
- Overrun: start with sample_in=8'h10; change to 8'hF0 and re-pulse conv_start at cycle 5 of busy -> overrun=1, busy still falls at cycle 12, read returns 8'h10.
- Read during busy: rd_cs held high from the edge -> data_oe=0 throughout busy, rises the cycle after busy falls, with data_out=8'h5C.
- Abort: ena low at busy cycle 6 -> busy=0 next cycle. Prior result (8'h5C) still read after ena returns; the new sample is not committed.
- Noise build (ADC_RESPONDER_NOISE_EN): 8 back-to-back conversions with sample_in=8'h80 -> every result within 8'h80..8'h83, and not all results equal.

Source files
------------

// File: rtl/adc_responder_pkg.sv
// Shared types and constants for the adc_responder ADC emulation.
// The LFSR constants are only used when ADC_RESPONDER_NOISE_EN is defined.
package adc_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StReady
  } state_e;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned CntW         = 8;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
  localparam logic [7:0] LfsrSeed = 8'hA5;
  localparam logic [7:0] LfsrTaps = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/adc_conv_timer.sv
// Loadable down-counter that times the CONVERT phase; done_o flags the final busy cycle.
module adc_conv_timer
  import adc_responder_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            run_i,
  output logic            done_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = run_i & (count_q == '0);

endmodule

// File: rtl/adc_responder.sv
// Responder side of the convStart/busy/rd_cs/data ADC handshake.
// Optional LSB jitter on results when ADC_RESPONDER_NOISE_EN is defined.
module adc_responder
  import adc_responder_pkg::*;
#(
  parameter int unsigned DATA_W      = DataWDefault,
  parameter int unsigned CONV_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              conv_start,
  input  logic              rd_cs,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              overrun
);

  state_e            state_q, state_d;
  logic              conv_start_q;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              overrun_q, overrun_d;
  logic              data_oe_q, data_oe_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] commit_val;
  logic              rise;
  logic              tmr_load, tmr_clear, tmr_run, tmr_done;

  assign rise = conv_start & ~conv_start_q;
  assign busy = (state_q == StConvert);

`ifdef ADC_RESPONDER_NOISE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign commit_val = shadow_q ^ DATA_W'(lfsr_q[1:0]);
`else
  assign commit_val = shadow_q;
`endif

  adc_conv_timer u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (CntW'(CONV_CYCLES - 1)),
    .run_i      (tmr_run),
    .done_o     (tmr_done)
  );

  assign tmr_run = ena & busy;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    result_d  = result_q;
    overrun_d = overrun_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    if (!ena) begin
      // Abort: result_q keeps the last completed conversion.
      state_d   = StIdle;
      overrun_d = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StReady: begin
          if (rise) begin
            shadow_d = sample_in;
            tmr_load = 1'b1;
            state_d  = StConvert;
          end
        end
        StConvert: begin
          // Edges during conversion, including the final cycle, only flag overrun.
          if (rise) begin
            overrun_d = 1'b1;
          end
          if (tmr_done) begin
            result_d = commit_val;
            state_d  = StReady;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    data_oe_d  = ena & rd_cs & ~busy;
    data_out_d = data_oe_d ? result_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      conv_start_q <= 1'b0;
      shadow_q     <= '0;
      result_q     <= '0;
      overrun_q    <= 1'b0;
      data_oe_q    <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      conv_start_q <= conv_start;
      shadow_q     <= shadow_d;
      result_q     <= result_d;
      overrun_q    <= overrun_d;
      data_oe_q    <= data_oe_d;
      data_out_q   <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_responder.sv
// Self-checking bench for adc_responder: per-cycle behavioural model plus directed literal checks.
module tb_adc_responder;

  localparam int unsigned W    = 8;
  localparam int unsigned CONV = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         conv_start;
  logic         rd_cs;
  logic [W-1:0] sample_in;
  logic         busy;
  logic [W-1:0] data_out;
  logic         data_oe;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  adc_responder #(.DATA_W(W), .CONV_CYCLES(CONV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .conv_start (conv_start),
    .rd_cs      (rd_cs),
    .sample_in  (sample_in),
    .busy       (busy),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: busy_left counts remaining busy cycles; outputs are what the DUT must show after an edge.
  int           m_busy_left;
  logic         m_prev_cs;
  logic [W-1:0] m_shadow, m_result, m_dout;
  logic         m_oe, m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_left = 0;
      m_prev_cs   = 1'b0;
      m_shadow    = '0;
      m_result    = '0;
      m_dout      = '0;
      m_oe        = 1'b0;
      m_ovr       = 1'b0;
    end else begin
      automatic logic r = conv_start && !m_prev_cs;
      m_prev_cs = conv_start;
      if (!ena) begin
        m_busy_left = 0;
        m_oe        = 1'b0;
        m_dout      = '0;
        m_ovr       = 1'b0;
      end else begin
        m_oe   = rd_cs && (m_busy_left == 0);
        m_dout = m_oe ? m_result : '0;
        if (m_busy_left > 0) begin
          if (r) m_ovr = 1'b1;
          m_busy_left--;
          if (m_busy_left == 0) m_result = m_shadow;
        end else if (r) begin
          m_shadow    = sample_in;
          m_busy_left = CONV;
        end
      end
    end
  end

  // Noise only perturbs the two LSBs, so compare the rest exactly.
`ifdef ADC_RESPONDER_NOISE_EN
  localparam logic [W-1:0] DMask = 8'hFC;
`else
  localparam logic [W-1:0] DMask = 8'hFF;
`endif

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("busy", W'(busy), W'(m_busy_left > 0));
      check("data_oe", W'(data_oe), W'(m_oe));
      check("data_out", data_out & DMask, m_dout & DMask);
      check("overrun", W'(overrun), W'(m_ovr));
    end
  end

  task automatic pulse(input logic [W-1:0] s);
    @(negedge clk);
    sample_in  = s;
    conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; optional re-edge at busy cycle re_at.
  task automatic count_busy(input int re_at, output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      conv_start = (n == re_at);
      @(negedge clk);
    end
    conv_start = 1'b0;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    ena        = 1'b1;
    conv_start = 1'b0;
    rd_cs      = 1'b0;
    sample_in  = 8'hAA;

    // Reset held with conv_start toggling
    repeat (4) begin
      @(negedge clk);
      conv_start = ~conv_start;
    end
    check("rst_busy", W'(busy), 8'h00);
    check("rst_oe", W'(data_oe), 8'h00);
    check("rst_dout", data_out, 8'h00);
    check("rst_ovr", W'(overrun), 8'h00);
    @(negedge clk);
    conv_start = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Read before any conversion drives zero
    rd_cs = 1'b1;
    @(negedge clk);
    check("idle_oe", W'(data_oe), 8'h01);
    check("idle_dout", data_out, 8'h00);
    rd_cs = 1'b0;

    // Basic conversion
    pulse(8'h5C);
    count_busy(0, n);
    check("basic_busy_len", W'(n), W'(CONV));
    rd_cs = 1'b1;
    @(negedge clk);
    check("basic_oe", W'(data_oe), 8'h01);
    check("basic_dout", data_out & DMask, 8'h5C);
    rd_cs = 1'b0;

    // Overrun: re-edge at busy cycle 5 with a different sample
    pulse(8'h10);
    sample_in = 8'hF0;
    count_busy(5, n);
    check("ovr_busy_len", W'(n), W'(CONV));
    check("ovr_flag", W'(overrun), 8'h01);
    rd_cs = 1'b1;
    @(negedge clk);
    check("ovr_dout", data_out & DMask, 8'h10);
    rd_cs = 1'b0;

    // Read held through busy
    @(negedge clk);
    rd_cs      = 1'b1;
    sample_in  = 8'h5C;
    conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
    count_busy(0, n);
    check("rdb_busy_len", W'(n), W'(CONV));
    check("rdb_oe_low", W'(data_oe), 8'h00);
    @(negedge clk);
    check("rdb_oe", W'(data_oe), 8'h01);
    check("rdb_dout", data_out & DMask, 8'h5C);
    rd_cs = 1'b0;

    // Abort at busy cycle 6
    pulse(8'h77);
    repeat (5) @(negedge clk);
    check("abort_busy_pre", W'(busy), 8'h01);
    ena = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), 8'h00);
    check("abort_ovr", W'(overrun), 8'h00);
    ena   = 1'b1;
    rd_cs = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_dout", data_out & DMask, 8'h5C);
    rd_cs = 1'b0;

    // Edge on the final conversion cycle completes, flags overrun, no restart
    pulse(8'h33);
    count_busy(CONV, n);
    check("final_busy_len", W'(n), W'(CONV));
    repeat (2) @(negedge clk);
    check("final_ovr", W'(overrun), 8'h01);
    check("final_no_restart", W'(busy), 8'h00);

    // Async reset mid-conversion
    pulse(8'h44);
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", W'(busy), 8'h00);
    check("arst_ovr", W'(overrun), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

`ifdef ADC_RESPONDER_NOISE_EN
    begin
      logic [W-1:0] res [8];
      bit           diff = 1'b0;
      for (int i = 0; i < 8; i++) begin
        pulse(8'h80);
        count_busy(0, n);
        rd_cs = 1'b1;
        @(negedge clk);
        res[i] = data_out;
        rd_cs  = 1'b0;
        checks++;
        if (res[i] < 8'h80 || res[i] > 8'h83) begin
          errors++;
          $display("FAIL noise_range: got %h expected 80..83", res[i]);
        end
        if (i > 0 && res[i] != res[0]) diff = 1'b1;
      end
      check("noise_varies", W'(diff), 8'h01);
    end
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
